vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
- Upstream stage of the pixel mapper/ROM/palette path: generates 640x480@60 VGA timing from a single 25 MHz pixel clock.
- Drives DrawX/DrawY and the active-video flag blank (1 = visible) into the mappers.
- Provides hs/vs, plus copies delayed to line up with the mappers' registered RGB.
- Provides frame_start/line_start strobes and a frame counter for sprite animation.

Parameters:
- H_VISIBLE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_VISIBLE, 480, visible lines
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BACK, 33, vertical back porch (lines)
- SYNC_DELAY, 2, vga_clk cycles of delay on hs_d/vs_d (mapper ROM read + RGB register); legal range 0..7

Ports:
- vga_clk  input  1  pixel clock, 25 MHz
- reset_n  input  1  asynchronous active-low reset
- DrawX  output  10  horizontal counter, 0..H_TOTAL-1
- DrawY  output  10  vertical counter, 0..V_TOTAL-1
- blank  output  1  1 when DrawX<H_VISIBLE and DrawY<V_VISIBLE
- hs  output  1  horizontal sync, active low, aligned with DrawX/DrawY
- vs  output  1  vertical sync, active low, aligned with DrawX/DrawY
- hs_d  output  1  hs delayed SYNC_DELAY cycles, for the monitor pins
- vs_d  output  1  vs delayed SYNC_DELAY cycles, for the monitor pins
- line_start  output  1  1-cycle pulse while DrawX==0
- frame_start  output  1  1-cycle pulse while DrawX==0 and DrawY==0
- frame_count  output  8  completed-frame counter, wraps

Behaviour:
- Derived constants: H_TOTAL = sum of the H_* parameters (800); V_TOTAL = sum of the V_* parameters (525).
- One clock (vga_clk). Reset asynchronous, active low (reset_n). All outputs come directly from flops; no combinational outputs.
- Reset values:
  - DrawX=H_TOTAL-1 (799), DrawY=V_TOTAL-1 (524)
  - blank=0, hs=1, vs=1, hs_d=1, vs_d=1 (every delay stage is 1)
  - line_start=0, frame_start=0, frame_count=0
  - internal first_frame flag=1
- Counting:
  - Every vga_clk: DrawX increments. When DrawX==H_TOTAL-1 it wraps to 0 and DrawY increments.
  - DrawY wraps from V_TOTAL-1 to 0 on the same edge that DrawX wraps.
  - The first edge after reset release therefore lands at (0,0).
- Alignment:
  - blank, hs, vs, line_start and frame_start are computed from the next-state counter values and registered on the same edge as the counters.
  - They always describe the DrawX/DrawY currently on the outputs (zero skew).
- hs=0 iff H_VISIBLE+H_FRONT <= DrawX < H_VISIBLE+H_FRONT+H_SYNC, i.e. DrawX 656..751.
- vs=0 iff V_VISIBLE+V_FRONT <= DrawY < V_VISIBLE+V_FRONT+V_SYNC, i.e. DrawY 490..491. vs is asserted for whole lines, including the blanking pixels.
- hs_d/vs_d: SYNC_DELAY-deep shift register of hs/vs, reset to all 1. SYNC_DELAY=0 means hs_d=hs and vs_d=vs. A mapper that registers its RGB twice (ROM + output flop) sees its pixel for (X,Y) coincide with hs_d/vs_d for (X,Y).
- frame_count:
  - Increments by 1 mod 256 on each wrap (H_TOTAL-1,V_TOTAL-1) to (0,0), except the wrap immediately after reset.
  - That first wrap only clears first_frame.
  - So frame_count is 0 during the first full frame after reset and 1 during the second. 255 wraps to 0.
- Reset mid-frame: every output returns to its reset value asynchronously. After release, timing restarts at (0,0) with a frame_start pulse on the first edge; no partial hs/vs pulse is emitted during reset.
- No inputs other than clock and reset. There is no stall, and the period is exactly H_TOTAL*V_TOTAL = 420000 cycles.

Test Plan:
- Reset release -> first edge: DrawX=0, DrawY=0, blank=1, frame_start=1, line_start=1, frame_count=0, hs=vs=1. Next edge: DrawX=1, both pulses 0.
- Line scan on one line -> blank=1 for DrawX 0..639, 0 for 640..799. hs=0 for exactly DrawX 656..751 (96 cycles). DrawX 799 -> 0 with DrawY +1 on the same edge.
- Full frame -> vs=0 for exactly DrawY 490..491 (1600 cycles). blank=0 for all DrawY>=480. frame_start pulses once every 420000 cycles.
- frame_count: run 3 frames -> values 0,1,2 at successive frame_starts. Force/run through 257 frames -> 255 wraps to 0.
- SYNC_DELAY=2 -> hs_d falls exactly 2 cycles after hs, i.e. while DrawX=658; vs_d likewise. SYNC_DELAY=0 -> hs_d==hs every cycle.
- Assert reset_n low at DrawX=700, DrawY=490 (hs=0, vs=0) -> immediately DrawX=799, DrawY=524, hs=vs=hs_d=vs_d=1, blank=0. Release -> restart at (0,0), frame_count=0, and no increment at the first wrap.

Source files
------------

// File: rtl/vga_timing_gen.sv
// 640x480@60 VGA raster timing: pixel/line counters, blanking, syncs, delayed
// syncs that line up with the mapper's registered RGB, and frame bookkeeping.
module vga_timing_gen #(
    parameter int unsigned H_VISIBLE  = 640,
    parameter int unsigned H_FRONT    = 16,
    parameter int unsigned H_SYNC     = 96,
    parameter int unsigned H_BACK     = 48,
    parameter int unsigned V_VISIBLE  = 480,
    parameter int unsigned V_FRONT    = 10,
    parameter int unsigned V_SYNC     = 2,
    parameter int unsigned V_BACK     = 33,
    parameter int unsigned SYNC_DELAY = 2
) (
    input  logic       vga_clk,
    input  logic       reset_n,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       blank,
    output logic       hs,
    output logic       vs,
    output logic       hs_d,
    output logic       vs_d,
    output logic       line_start,
    output logic       frame_start,
    output logic [7:0] frame_count
);

    localparam int unsigned CW      = 10;
    localparam int unsigned FW      = 8;
    localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_VIS    = CW'(H_VISIBLE);
    localparam logic [CW-1:0] V_VIS    = CW'(V_VISIBLE);
    localparam logic [CW-1:0] HS_BEGIN = CW'(H_VISIBLE + H_FRONT);
    localparam logic [CW-1:0] HS_END   = CW'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [CW-1:0] VS_BEGIN = CW'(V_VISIBLE + V_FRONT);
    localparam logic [CW-1:0] VS_END   = CW'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [CW-1:0] x_q, x_d;
    logic [CW-1:0] y_q, y_d;
    logic          blank_q, blank_d;
    logic          hsync_q, hsync_d;
    logic          vsync_q, vsync_d;
    logic          line_start_q, line_start_d;
    logic          frame_start_q, frame_start_d;
    logic [FW-1:0] frame_count_q, frame_count_d;
    logic          first_frame_q, first_frame_d;
    logic          wrap_x;
    logic          wrap_frame;

    // Next raster position plus every flag decoded from it, so the registered
    // flags describe the same pixel as the registered counters.
    always_comb begin
        wrap_x     = (x_q == H_LAST);
        wrap_frame = wrap_x && (y_q == V_LAST);

        x_d = wrap_x ? '0 : x_q + CW'(1);
        y_d = y_q;
        if (wrap_x) begin
            y_d = (y_q == V_LAST) ? '0 : y_q + CW'(1);
        end

        blank_d       = (x_d < H_VIS) && (y_d < V_VIS);
        hsync_d       = !((x_d >= HS_BEGIN) && (x_d < HS_END));
        vsync_d       = !((y_d >= VS_BEGIN) && (y_d < VS_END));
        line_start_d  = (x_d == '0);
        frame_start_d = (x_d == '0) && (y_d == '0);

        // The wrap out of the reset position is not a completed frame.
        first_frame_d = first_frame_q;
        frame_count_d = frame_count_q;
        if (wrap_frame) begin
            if (first_frame_q) begin
                first_frame_d = 1'b0;
            end else begin
                frame_count_d = frame_count_q + FW'(1);
            end
        end
    end

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            x_q           <= H_LAST;
            y_q           <= V_LAST;
            blank_q       <= 1'b0;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            frame_count_q <= '0;
            first_frame_q <= 1'b1;
        end else begin
            x_q           <= x_d;
            y_q           <= y_d;
            blank_q       <= blank_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
            frame_count_q <= frame_count_d;
            first_frame_q <= first_frame_d;
        end
    end

    // Sync delay line matching the mapper's ROM read + RGB output register.
    if (SYNC_DELAY == 0) begin : g_no_delay
        assign hs_d = hsync_q;
        assign vs_d = vsync_q;
    end else begin : g_delay
        logic [SYNC_DELAY-1:0] hs_pipe_q, hs_pipe_d;
        logic [SYNC_DELAY-1:0] vs_pipe_q, vs_pipe_d;

        always_comb begin
            hs_pipe_d = SYNC_DELAY'({hs_pipe_q, hsync_q});
            vs_pipe_d = SYNC_DELAY'({vs_pipe_q, vsync_q});
        end

        always_ff @(posedge vga_clk or negedge reset_n) begin
            if (!reset_n) begin
                hs_pipe_q <= '1;
                vs_pipe_q <= '1;
            end else begin
                hs_pipe_q <= hs_pipe_d;
                vs_pipe_q <= vs_pipe_d;
            end
        end

        assign hs_d = hs_pipe_q[SYNC_DELAY-1];
        assign vs_d = vs_pipe_q[SYNC_DELAY-1];
    end

    assign DrawX       = x_q;
    assign DrawY       = y_q;
    assign blank       = blank_q;
    assign hs          = hsync_q;
    assign vs          = vsync_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;
    assign frame_count = frame_count_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: full-size raster with delays 2 and 0, plus a shrunken
// raster (16x12 totals) for multi-frame counter wrap and mid-frame reset.
module tb_vga_timing_gen;

    logic clk;
    logic rst_n;
    logic rst_s_n;

    logic [9:0] d_x, d_y, z_x, z_y, s_x, s_y;
    logic       d_blank, d_hs, d_vs, d_hsd, d_vsd, d_ls, d_fs;
    logic       z_blank, z_hs, z_vs, z_hsd, z_vsd, z_ls, z_fs;
    logic       s_blank, s_hs, s_vs, s_hsd, s_vsd, s_ls, s_fs;
    logic [7:0] d_fc, z_fc, s_fc;

    int unsigned tests_run;
    int unsigned tests_failed;
    int unsigned n;
    int unsigned s_base;
    bit          s_active;

    int unsigned d_hs_low, d_blank_cnt, d_ls_cnt, d_fs_cnt, z_err;
    int unsigned s_vs_low, s_blank_cnt;

    localparam int unsigned S_FRAME = 192;

    vga_timing_gen u_def (
        .vga_clk(clk), .reset_n(rst_n), .DrawX(d_x), .DrawY(d_y), .blank(d_blank),
        .hs(d_hs), .vs(d_vs), .hs_d(d_hsd), .vs_d(d_vsd), .line_start(d_ls),
        .frame_start(d_fs), .frame_count(d_fc)
    );

    vga_timing_gen #(.SYNC_DELAY(0)) u_zero (
        .vga_clk(clk), .reset_n(rst_n), .DrawX(z_x), .DrawY(z_y), .blank(z_blank),
        .hs(z_hs), .vs(z_vs), .hs_d(z_hsd), .vs_d(z_vsd), .line_start(z_ls),
        .frame_start(z_fs), .frame_count(z_fc)
    );

    vga_timing_gen #(
        .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
        .V_VISIBLE(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(2), .SYNC_DELAY(2)
    ) u_small (
        .vga_clk(clk), .reset_n(rst_s_n), .DrawX(s_x), .DrawY(s_y), .blank(s_blank),
        .hs(s_hs), .vs(s_vs), .hs_d(s_hsd), .vs_d(s_vsd), .line_start(s_ls),
        .frame_start(s_fs), .frame_count(s_fc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int unsigned n;
        logic [9:0]  x;
        logic [9:0]  y;
        logic        blank;
        logic        hs;
        logic        hsd;
        logic        ls;
        logic        fs;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, n);
        end
    endtask

    task automatic set_vec(input int idx, input int unsigned vn, input int unsigned vx,
                           input int unsigned vy, input logic b, input logic h,
                           input logic hd, input logic l, input logic f);
        vecs[idx].n     = vn;
        vecs[idx].x     = 10'(vx);
        vecs[idx].y     = 10'(vy);
        vecs[idx].blank = b;
        vecs[idx].hs    = h;
        vecs[idx].hsd   = hd;
        vecs[idx].ls    = l;
        vecs[idx].fs    = f;
    endtask

    // One clock edge, sampled 1 time unit later, with running statistics.
    task automatic step();
        int unsigned ns;
        int unsigned mx;
        logic        mhs;
        @(posedge clk);
        #1;
        n++;
        if (n <= 800) begin
            mx  = n - 1;
            mhs = !((mx >= 656) && (mx < 752));
            if (!d_hs) d_hs_low++;
            if (d_blank) d_blank_cnt++;
            if (d_ls) d_ls_cnt++;
            if (z_hsd !== mhs || z_vsd !== 1'b1) z_err++;
        end
        if (n <= 1441 && d_fs) d_fs_cnt++;
        if (s_active) begin
            ns = n - s_base;
            if (s_base == 0 && ns <= S_FRAME) begin
                if (!s_vs) s_vs_low++;
                if (s_blank) s_blank_cnt++;
            end
            if (((ns - 1) % S_FRAME) == 0 || s_fs) begin
                check("small_frame_start", 32'(s_fs), 32'(((ns - 1) % S_FRAME) == 0));
                check("small_frame_count", 32'(s_fc), ((ns - 1) / S_FRAME) % 256);
            end
            if (s_base == 0) begin
                if (ns == 129) begin
                    check("small_vs_fall", 32'(s_vs), 0);
                    check("small_vsd_at_x0", 32'(s_vsd), 1);
                end
                if (ns == 130) check("small_vsd_at_x1", 32'(s_vsd), 1);
                if (ns == 131) check("small_vsd_fall_x2", 32'(s_vsd), 0);
                if (ns == 161) begin
                    check("small_vs_rise", 32'(s_vs), 1);
                    check("small_vsd_still_low", 32'(s_vsd), 0);
                end
                if (ns == 163) check("small_vsd_rise", 32'(s_vsd), 1);
            end
        end
    endtask

    initial begin
        tests_run = 0; tests_failed = 0; n = 0; s_base = 0; s_active = 1'b0;
        d_hs_low = 0; d_blank_cnt = 0; d_ls_cnt = 0; d_fs_cnt = 0; z_err = 0;
        s_vs_low = 0; s_blank_cnt = 0;
        rst_n = 1'b0; rst_s_n = 1'b0;

        //          n     x    y  blk hs hsd ls fs
        set_vec(0,  1,    0,   0, 1, 1, 1, 1, 1);
        set_vec(1,  2,    1,   0, 1, 1, 1, 0, 0);
        set_vec(2,  640,  639, 0, 1, 1, 1, 0, 0);
        set_vec(3,  641,  640, 0, 0, 1, 1, 0, 0);
        set_vec(4,  656,  655, 0, 0, 1, 1, 0, 0);
        set_vec(5,  657,  656, 0, 0, 0, 1, 0, 0);
        set_vec(6,  658,  657, 0, 0, 0, 1, 0, 0);
        set_vec(7,  659,  658, 0, 0, 0, 0, 0, 0);
        set_vec(8,  752,  751, 0, 0, 0, 0, 0, 0);
        set_vec(9,  753,  752, 0, 0, 1, 0, 0, 0);
        set_vec(10, 754,  753, 0, 0, 1, 0, 0, 0);
        set_vec(11, 755,  754, 0, 0, 1, 1, 0, 0);
        set_vec(12, 800,  799, 0, 0, 1, 1, 0, 0);
        set_vec(13, 801,  0,   1, 1, 1, 1, 1, 0);
        set_vec(14, 1441, 640, 1, 0, 1, 1, 0, 0);

        repeat (3) @(posedge clk);
        #1;
        check("rst_x", 32'(d_x), 799);
        check("rst_y", 32'(d_y), 524);
        check("rst_blank", 32'(d_blank), 0);
        check("rst_hs_vs", 32'({d_hs, d_vs, d_hsd, d_vsd}), 32'hF);
        check("rst_pulses", 32'({d_ls, d_fs}), 0);
        check("rst_fc", 32'(d_fc), 0);
        check("rst_zero_dly_syncs", 32'({z_hsd, z_vsd}), 3);
        check("rst_small_xy", 32'({s_x, s_y}), 32'({10'd15, 10'd11}));

        rst_n = 1'b1; rst_s_n = 1'b1; s_active = 1'b1;

        for (int i = 0; i < 15; i++) begin
            while (n < vecs[i].n) step();
            check($sformatf("v%0d_x", i), 32'(d_x), 32'(vecs[i].x));
            check($sformatf("v%0d_y", i), 32'(d_y), 32'(vecs[i].y));
            check($sformatf("v%0d_blank", i), 32'(d_blank), 32'(vecs[i].blank));
            check($sformatf("v%0d_hs", i), 32'(d_hs), 32'(vecs[i].hs));
            check($sformatf("v%0d_hs_d", i), 32'(d_hsd), 32'(vecs[i].hsd));
            check($sformatf("v%0d_vs", i), 32'({d_vs, d_vsd}), 3);
            check($sformatf("v%0d_line_start", i), 32'(d_ls), 32'(vecs[i].ls));
            check($sformatf("v%0d_frame_start", i), 32'(d_fs), 32'(vecs[i].fs));
            check($sformatf("v%0d_fc", i), 32'(d_fc), 0);
        end

        check("line_hs_low_cycles", d_hs_low, 96);
        check("line_blank_cycles", d_blank_cnt, 640);
        check("line_start_pulses", d_ls_cnt, 1);
        check("frame_start_pulses", d_fs_cnt, 1);
        check("zero_delay_sync_err", z_err, 0);
        check("small_vs_low_cycles", s_vs_low, 32);
        check("small_blank_cycles", s_blank_cnt, 48);

        // Through 257 small frames (255 -> 0 wrap), then to X=12, Y=8 of frame 258.
        while (n < 49485) step();
        check("pre_rst_xy", 32'({s_x, s_y}), 32'({10'd12, 10'd8}));
        check("pre_rst_syncs", 32'({s_hs, s_hsd, s_vs, s_vsd}), 0);
        check("pre_rst_fc", 32'(s_fc), 1);

        #2;
        rst_s_n = 1'b0;
        s_active = 1'b0;
        #1;
        check("mid_rst_xy", 32'({s_x, s_y}), 32'({10'd15, 10'd11}));
        check("mid_rst_syncs", 32'({s_hs, s_hsd, s_vs, s_vsd}), 32'hF);
        check("mid_rst_blank", 32'(s_blank), 0);
        check("mid_rst_pulses", 32'({s_ls, s_fs}), 0);
        check("mid_rst_fc", 32'(s_fc), 0);
        step();
        step();
        check("held_rst_syncs", 32'({s_hs, s_hsd, s_vs, s_vsd}), 32'hF);
        rst_s_n = 1'b1;
        s_base = n;
        s_active = 1'b1;

        step();
        check("restart_xy", 32'({s_x, s_y}), 0);
        check("restart_blank", 32'(s_blank), 1);
        check("restart_pulses", 32'({s_ls, s_fs}), 3);
        check("restart_syncs", 32'({s_hs, s_vs}), 3);
        while (n - s_base < 2 * S_FRAME + 1) step();
        check("restart_fc_third_frame", 32'(s_fc), 2);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
